rip_fifo_unpack: RTL

- Width-down converter on the read side of rip_fifo_async, in the r_clk domain.
- Pops IN_WIDTH-bit entries from the FIFO's first-word-fall-through read port (r_data is valid whenever r_empty is low).
- Emits each entry as IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit slices on a valid/ready stream toward the consumer (core load path, UART TX).
- Back-to-back entries stream with no bubble cycle.

---
 rtl/rip_fifo_unpack.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rip_fifo_unpack.sv
// rip_fifo_unpack
//
// Width-down converter on the read side of rip_fifo_async (r_clk domain).
// Pops IN_WIDTH-bit entries from the FIFO's first-word-fall-through read port
// and emits each one as RATIO = IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit
// slices on a valid/ready stream. The last slice of an entry and the pop of
// the next entry share a cycle, so back-to-back entries stream with no bubble.
//
// Ports
//   clk         in   single clock (the FIFO's r_clk)
//   rst         in   synchronous, active-high reset
//   fifo_empty  in   FIFO r_empty
//   fifo_data   in   FIFO r_data, valid whenever fifo_empty is low
//   fifo_r_en   out  pop strobe to FIFO r_en (combinational)
//   flush       in   discard the held entry; highest priority
//   out_valid   out  slice valid (registered)
//   out_ready   in   consumer accepts the slice
//   out_data    out  current slice (registered source, mux on idx)
//   out_last    out  current slice is the final slice of its entry
//
// Build option
//   RIP_FIFO_UNPACK_MSB_FIRST_EN  when defined, the most significant slice of
//   each entry goes out first. out_last still marks the final slice sent.
//
// State table
//   state    | meaning
//   ST_EMPTY | no entry held; out_valid low; pops as soon as FIFO non-empty
//   ST_HOLD  | entry held in hold_q; slice idx_q presented on out_data

module rip_fifo_unpack #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  output logic                 fifo_r_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  if ((RATIO < 2) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_cfg
    $error("rip_fifo_unpack: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 slices");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [IN_WIDTH-1:0]   hold_q,  hold_d;

  // Slice view of the hold register; element 0 is the least significant slice.
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_slices;
  logic [IDX_W-1:0]                slice_sel;

  assign hold_slices = hold_q;

`ifdef RIP_FIFO_UNPACK_MSB_FIRST_EN
  assign slice_sel = IDX_LAST - idx_q;
`else
  assign slice_sel = idx_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Output logic. fifo_r_en depends combinationally on out_ready and
  // fifo_empty so the next entry loads on the same edge the last slice is
  // accepted. Reset suppresses the pop so no entry is lost in the reset cycle.
  always_comb begin
    out_valid = (state_q == ST_HOLD);
    out_last  = (idx_q == IDX_LAST);
    out_data  = hold_slices[slice_sel];
    fifo_r_en = !rst && !flush && !fifo_empty &&
                ((state_q == ST_EMPTY) || (out_ready && out_last));
  end

  // Next-state logic. Flush wins over everything; a transfer coinciding with
  // flush counts as delivered and the rest of the entry is dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
    end else if (fifo_r_en) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      hold_d  = fifo_data;
    end else if ((state_q == ST_HOLD) && out_ready) begin
      if (out_last) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

endmodule
